alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the execute stage (port 0) and the branch-resolution unit (port 1).
- Each requester sees a valid/ready request channel and a valid/ready response channel.
- Two-stage pipeline: an issue register drives the ALU, and per-requester response registers capture the result.
- Round-robin arbitration; throughput of one operation per cycle.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 4, alu_op width; encodings from alu_defs.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req_a  in  2*DATA_W  operand a; slice i for requester i.
- req_b  in  2*DATA_W  operand b; slice i.
- req_op  in  2*OP_W  alu_defs opcode; slice i.
- rsp_valid  out  2  result available for requester i.
- rsp_ready  in  2  requester i consumes its result.
- rsp_result  out  2*DATA_W  result; slice i.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_op  out  OP_W  to ALU alu_op.
- alu_result  in  DATA_W  from ALU result (combinational).

Behaviour:
- State:
  - Issue register: iss_valid, iss_a, iss_b, iss_op, iss_owner.
  - Response registers: rsp_valid[i], rsp_result[i].
  - Round-robin pointer: last_grant (1 bit).
- Reset (async, rst_n=0):
  - iss_valid=0, rsp_valid=2'b00, rsp_result=0, last_grant=1 (so requester 0 wins the first tie).
  - req_ready=2'b00 while in reset.
- ALU drive:
  - alu_a/alu_b/alu_op = iss_a/iss_b/iss_op when iss_valid.
  - Otherwise alu_a=0, alu_b=0, alu_op=NOP.
- Response drain: drain[i] = rsp_valid[i] & rsp_ready[i].
- Issue advance: adv = iss_valid & (!rsp_valid[iss_owner] | drain[iss_owner]).
- On adv:
  - rsp_result[iss_owner] <= alu_result.
  - rsp_valid[iss_owner] <= 1.
  - The other response register only clears on its own drain.
  - If drain and adv hit the same register in one cycle, the new result is loaded and rsp_valid stays 1.
- Accept condition: can_accept = !iss_valid | adv.
- Arbitration (combinational):
  - Only one valid → that one is granted.
  - Both valid → grant !last_grant.
  - req_ready[g] = can_accept & req_valid[g]; the other bit is 0.
  - req_ready never asserts without the matching req_valid.
- On grant & can_accept:
  - Issue register loads the granted slice; iss_owner=g, last_grant=g.
  - Otherwise, if adv: iss_valid <= 0.
- Latency:
  - Request handshake at edge N → iss_valid during cycle N+1 → rsp_valid[i]=1 during cycle N+2.
  - rsp_result is stable while rsp_valid & !rsp_ready.
- Backpressure:
  - If the owner's response register is full and not draining, the issue register holds, so ALU inputs are stable and req_ready=00.
  - Head-of-line blocking across requesters is accepted behaviour.
- Stability rules:
  - Requesters hold req_* stable while req_valid & !req_ready.
  - Dropping req_valid before acceptance is permitted; the arbiter must not latch that request.
- Reset mid-operation: any in-flight issue or response content is discarded immediately, and no stale rsp_valid appears after release.
- Opcodes are passed through unmodified; there is no width extension.

Test Plan:
- Single request: port 0 sends ADD a=5 b=7 with rsp_ready=1 → rsp_valid[0]=1 two cycles after the handshake, rsp_result[0]=12; port 1 untouched.
- Simultaneous: both valid from reset (p0 SUB 10,3; p1 XOR 0xF0,0xFF) → p0 granted first (7 at N+2), then p1 (0x0F at N+3); next tie grants p1 first.
- Continuous contention: both valid for 8 cycles → grants alternate 0,1,0,1; 8 results, one per cycle.
- Backpressure: rsp_ready[1]=0, port 1 issues BEQ 4,4 then SLL 1,3 → first result 1 held; second op held in issue with alu_op=SLL stable and req_ready=00; raise rsp_ready → 1 then 8 delivered in order.
- Same-cycle drain+load: rsp_ready[0]=1 and back-to-back port-0 ops ADD 1,1 / ADD 2,2 → rsp_valid[0] stays high two consecutive cycles with 2 then 4.
- Reset mid-op: assert rst_n=0 one cycle after a handshake → rsp_valid=00, alu_op=NOP, req_ready=00 immediately; after release the first tie grants port 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// An issue register drives the ALU; one response register per requester captures the result.

module alu_share_rsp_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              drain,
   output logic              valid,
   output logic [DATA_W-1:0] result
);

   // A load in the same cycle as a drain wins, so valid stays high with the new data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         result <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         result <= load_data;
      end else if (drain) begin
         valid  <= 1'b0;
      end
   end

endmodule

module alu_share_arbiter #(
   parameter int              DATA_W = 32,
   parameter int              OP_W   = 4,
   parameter logic [OP_W-1:0] NOP_OP = '1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   input  logic [2*OP_W-1:0]   req_op,
   output logic [1:0]          rsp_valid,
   input  logic [1:0]          rsp_ready,
   output logic [2*DATA_W-1:0] rsp_result,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_op,
   input  logic [DATA_W-1:0]   alu_result
);

   localparam int NUM_REQ = 2;

   logic [NUM_REQ-1:0][DATA_W-1:0] a_v, b_v, res_v;
   logic [NUM_REQ-1:0][OP_W-1:0]   op_v;

   logic              iss_valid;
   logic [DATA_W-1:0] iss_a, iss_b;
   logic [OP_W-1:0]   iss_op;
   logic              iss_owner;
   logic              last_grant;

   logic [NUM_REQ-1:0] drain, load;
   logic               adv, can_accept;
   logic               gnt_any, gnt_idx, take;

   assign a_v        = req_a;
   assign b_v        = req_b;
   assign op_v       = req_op;
   assign rsp_result = res_v;

   assign drain      = rsp_valid & rsp_ready;
   assign adv        = iss_valid & (~rsp_valid[iss_owner] | drain[iss_owner]);
   assign can_accept = ~iss_valid | adv;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = 1'b0;
      case (req_valid)
         2'b01: begin gnt_any = 1'b1; gnt_idx = 1'b0;        end
         2'b10: begin gnt_any = 1'b1; gnt_idx = 1'b1;        end
         2'b11: begin gnt_any = 1'b1; gnt_idx = ~last_grant; end
         default: ;
      endcase
   end

   // rst_n gates the handshake so nothing is offered while reset is held.
   assign take      = gnt_any & can_accept & rst_n;
   assign req_ready = take ? (2'b01 << gnt_idx) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid  <= 1'b0;
         iss_a      <= '0;
         iss_b      <= '0;
         iss_op     <= NOP_OP;
         iss_owner  <= 1'b0;
         last_grant <= 1'b1;
      end else if (take) begin
         iss_valid  <= 1'b1;
         iss_a      <= a_v[gnt_idx];
         iss_b      <= b_v[gnt_idx];
         iss_op     <= op_v[gnt_idx];
         iss_owner  <= gnt_idx;
         last_grant <= gnt_idx;
      end else if (adv) begin
         iss_valid  <= 1'b0;
      end
   end

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = NOP_OP;
      if (iss_valid) begin
         alu_a  = iss_a;
         alu_b  = iss_b;
         alu_op = iss_op;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
      assign load[i] = adv & (iss_owner == 1'(i));

      alu_share_rsp_reg #(.DATA_W(DATA_W)) u_rsp (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[i]),
         .load_data (alu_result),
         .drain     (drain[i]),
         .valid     (rsp_valid[i]),
         .result    (res_v[i])
      );
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios followed by a randomized phase.
module tb_alu_share_arbiter;
   localparam int DW = 32;
   localparam int OW = 4;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                          OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SLT = 4'd7,
                          OP_BEQ = 4'd8, OP_NOP = 4'hF;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
   logic [2*DW-1:0] req_a = '0, req_b = '0, rsp_result;
   logic [2*OW-1:0] req_op = '0;
   logic [DW-1:0]   alu_a, alu_b, alu_result;
   logic [OW-1:0]   alu_op;

   alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .NOP_OP(OP_NOP)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_result(alu_result));

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] alu_f(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
      case (op)
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_XOR: return a ^ b;
         OP_SLL: return a << b[4:0];
         OP_SRL: return a >> b[4:0];
         OP_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_BEQ: return (a == b) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   // The external ALU
   assign alu_result = alu_f(alu_op, alu_a, alu_b);

   int vecs = 0, errs = 0, cyc_n = 0;
   always @(posedge clk) cyc_n++;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] res(int i);
      return rsp_result[i*DW +: DW];
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [DW-1:0] q0[$], q1[$];
   int            c0[$], c1[$];
   logic          tb_last;
   logic [1:0]    prev_hold;
   logic [DW-1:0] prev_res0, prev_res1;

   function automatic logic [DW-1:0] req_exp(int i);
      return alu_f(req_op[i*OW +: OW], req_a[i*DW +: DW], req_b[i*DW +: DW]);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q0.delete(); q1.delete(); c0.delete(); c1.delete();
         tb_last   = 1'b1;
         prev_hold = 2'b00;
      end else begin
         if (prev_hold[0]) begin
            chk("hold_valid0", DW'(rsp_valid[0]), DW'(1));
            chk("hold_result0", res(0), prev_res0);
         end
         if (prev_hold[1]) begin
            chk("hold_valid1", DW'(rsp_valid[1]), DW'(1));
            chk("hold_result1", res(1), prev_res1);
         end
         for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                  vecs++; errs++;
                  $display("FAIL stale_rsp%0d: got result %0h expected no response", i, res(i));
               end else begin
                  logic [DW-1:0] e;
                  int            c;
                  if (i == 0) begin e = q0.pop_front(); c = c0.pop_front(); end
                  else        begin e = q1.pop_front(); c = c1.pop_front(); end
                  chk($sformatf("rsp%0d", i), res(i), e);
                  chk($sformatf("lat%0d_ge2", i), DW'(cyc_n - c >= 2), DW'(1));
               end
            end
         end
         if (req_ready != 2'b00) begin
            chk("ready_onehot_sub", DW'(((req_ready & ~req_valid) == 2'b00) && $onehot(req_ready)), DW'(1));
            if (req_valid == 2'b11) chk("rr_tie", DW'(req_ready), DW'(tb_last ? 2'b01 : 2'b10));
            tb_last = req_ready[1];
            if (req_ready[0]) begin q0.push_back(req_exp(0)); c0.push_back(cyc_n); end
            if (req_ready[1]) begin q1.push_back(req_exp(1)); c1.push_back(cyc_n); end
         end
         prev_hold = rsp_valid & ~rsp_ready;
         prev_res0 = res(0);
         prev_res1 = res(1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(output logic [1:0] hs);
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
      req_valid[i]        = 1'b1;
      req_op[i*OW +: OW]  = op;
      req_a[i*DW +: DW]   = a;
      req_b[i*DW +: DW]   = b;
   endtask

   task automatic rnd_req(int i);
      logic [3:0] op;
      op = 4'($urandom_range(0, 9));
      if (op == 4'd9) op = OP_NOP;
      set_req(i, op, ($urandom_range(0, 1) != 0) ? $urandom() : DW'($urandom_range(0, 40)),
              ($urandom_range(0, 1) != 0) ? $urandom() : DW'($urandom_range(0, 40)));
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic idle(int n);
      logic [1:0] hs;
      for (int k = 0; k < n; k++) cyc(hs);
   endtask

   initial begin
      logic [1:0] hs;
      int         accepts;
      #1;
      req_valid = 2'b11;
      #1;
      chk("rst_ready", DW'(req_ready), DW'(0));
      chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      chk("rst_alu_op", DW'(alu_op), DW'(OP_NOP));
      chk("rst_result", rsp_result[DW-1:0] | rsp_result[2*DW-1:DW], DW'(0));
      do_reset();

      // single request
      rsp_ready = 2'b11;
      set_req(0, OP_ADD, 5, 7);
      cyc(hs); chk("t1_hs", DW'(hs), DW'(2'b01));
      req_valid[0] = 1'b0;
      chk("t1_alu_op", DW'(alu_op), DW'(OP_ADD));
      chk("t1_alu_a", alu_a, 5);
      chk("t1_rsp_n1", DW'(rsp_valid), DW'(0));
      cyc(hs); chk("t1_rsp_n2", DW'(rsp_valid), DW'(2'b01)); chk("t1_res", res(0), 12);
      cyc(hs); chk("t1_rsp_clr", DW'(rsp_valid), DW'(0));
      chk("t1_alu_idle", DW'(alu_op), DW'(OP_NOP));

      // simultaneous from reset, then a second tie
      do_reset();
      rsp_ready = 2'b11;
      set_req(0, OP_SUB, 10, 3);
      set_req(1, OP_XOR, 32'hF0, 32'hFF);
      cyc(hs); chk("t2_first", DW'(hs), DW'(2'b01));
      set_req(0, OP_ADD, 100, 23);
      cyc(hs); chk("t2_tie2", DW'(hs), DW'(2'b10));
      req_valid[1] = 1'b0;
      chk("t2_rsp0_v", DW'(rsp_valid), DW'(2'b01)); chk("t2_rsp0", res(0), 7);
      cyc(hs); chk("t2_third", DW'(hs), DW'(2'b01));
      req_valid[0] = 1'b0;
      chk("t2_rsp1_v", DW'(rsp_valid), DW'(2'b10)); chk("t2_rsp1", res(1), 32'h0F);
      cyc(hs); chk("t2_rsp0b_v", DW'(rsp_valid), DW'(2'b01)); chk("t2_rsp0b", res(0), 123);
      idle(2);

      // continuous contention
      do_reset();
      rsp_ready = 2'b11;
      rnd_req(0); rnd_req(1);
      accepts = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(hs);
         chk($sformatf("t3_grant%0d", k), DW'(hs), DW'((k % 2 == 0) ? 2'b01 : 2'b10));
         if (hs != 2'b00) accepts++;
         if (k >= 1) chk($sformatf("t3_rsp%0d", k), DW'(rsp_valid), DW'((k % 2 == 1) ? 2'b01 : 2'b10));
         if (hs[0]) rnd_req(0);
         if (hs[1]) rnd_req(1);
      end
      chk("t3_accepts", DW'(accepts), DW'(8));
      req_valid = 2'b00;
      idle(3);

      // backpressure on port 1
      do_reset();
      rsp_ready = 2'b01;
      set_req(1, OP_BEQ, 4, 4);
      cyc(hs); chk("t4_hs1", DW'(hs), DW'(2'b10));
      set_req(1, OP_SLL, 1, 3);
      cyc(hs); chk("t4_hs2", DW'(hs), DW'(2'b10));
      req_valid[1] = 1'b0;
      set_req(0, OP_ADD, 9, 9);
      chk("t4_first_v", DW'(rsp_valid[1]), DW'(1)); chk("t4_first", res(1), 1);
      for (int k = 0; k < 3; k++) begin
         cyc(hs);
         chk("t4_blocked", DW'(hs), DW'(0));
         chk("t4_alu_op", DW'(alu_op), DW'(OP_SLL));
         chk("t4_alu_a", alu_a, 1);
         chk("t4_alu_b", alu_b, 3);
         chk("t4_held", res(1), 1);
      end
      rsp_ready = 2'b11;
      cyc(hs); chk("t4_release_hs", DW'(hs), DW'(2'b01));
      req_valid[0] = 1'b0;
      chk("t4_second_v", DW'(rsp_valid[1]), DW'(1)); chk("t4_second", res(1), 8);
      idle(3);

      // same-cycle drain and load
      do_reset();
      rsp_ready = 2'b11;
      set_req(0, OP_ADD, 1, 1);
      cyc(hs);
      set_req(0, OP_ADD, 2, 2);
      cyc(hs); chk("t5_hs2", DW'(hs), DW'(2'b01));
      req_valid[0] = 1'b0;
      chk("t5_v1", DW'(rsp_valid[0]), DW'(1)); chk("t5_r1", res(0), 2);
      cyc(hs); chk("t5_v2", DW'(rsp_valid[0]), DW'(1)); chk("t5_r2", res(0), 4);
      idle(2);

      // reset mid-operation
      do_reset();
      rsp_ready = 2'b00;
      set_req(0, OP_ADD, 3, 4);
      cyc(hs);
      req_valid[0] = 1'b0;
      set_req(1, OP_SUB, 9, 1);
      cyc(hs); chk("t6_hs", DW'(hs), DW'(2'b10));
      set_req(0, OP_OR, 6, 1);
      set_req(1, OP_AND, 7, 3);
      rst_n = 1'b0;
      #1;
      chk("t6_rsp_valid", DW'(rsp_valid), DW'(0));
      chk("t6_alu_op", DW'(alu_op), DW'(OP_NOP));
      chk("t6_ready", DW'(req_ready), DW'(0));
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t6_post_rsp", DW'(rsp_valid), DW'(0));
      cyc(hs); chk("t6_post_tie", DW'(hs), DW'(2'b01));
      req_valid[0] = 1'b0;
      rsp_ready = 2'b11;
      cyc(hs);
      req_valid = 2'b00;
      idle(3);

      // randomized phase
      do_reset();
      hs = 2'b00;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] || hs[i]) begin
               if ($urandom_range(0, 9) < 6) rnd_req(i);
               else req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = 2'($urandom_range(0, 3));
         cyc(hs);
      end
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      for (int k = 0; k < 20 && (q0.size() + q1.size()) != 0; k++) cyc(hs);
      idle(1);
      chk("drain_empty", DW'(q0.size() + q1.size()), DW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
